// File: rtl/jam_pkg.sv
// Shared sizing, types and FSM encoding for the job-assignment cost table.
package jam_pkg;

  localparam int N_JOB     = 8;
  localparam int COST_W    = 7;
  localparam int IDX_W     = $clog2(N_JOB);
  localparam int TBL_W     = 2 * IDX_W;
  localparam int TBL_DEPTH = N_JOB * N_JOB;

  typedef logic [COST_W-1:0] cost_t;
  typedef logic [TBL_W-1:0]  tbl_idx_t;
  typedef logic [IDX_W-1:0]  job_idx_t;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam tbl_idx_t LAST_IDX = tbl_idx_t'(TBL_DEPTH - 1);

endpackage

// File: rtl/jam_cost_rom_if.sv
// Cost-table bus between the solver/loader (master) and jam_cost_rom (slave).
// RdCount exists only when JAM_COST_RDCNT_EN is defined.
interface jam_cost_rom_if;
  import jam_pkg::*;

  logic     LoadValid;
  logic     LoadReady;
  cost_t    LoadData;
  logic     Reload;
  logic     TableRdy;
  job_idx_t W;
  job_idx_t J;
  cost_t    Cost;
`ifdef JAM_COST_RDCNT_EN
  logic [15:0] RdCount;

  modport master (
    output LoadValid, LoadData, Reload, W, J,
    input  LoadReady, TableRdy, Cost, RdCount
  );
  modport slave (
    input  LoadValid, LoadData, Reload, W, J,
    output LoadReady, TableRdy, Cost, RdCount
  );
`else
  modport master (
    output LoadValid, LoadData, Reload, W, J,
    input  LoadReady, TableRdy, Cost
  );
  modport slave (
    input  LoadValid, LoadData, Reload, W, J,
    output LoadReady, TableRdy, Cost
  );
`endif

endinterface

// File: rtl/jam_cost_mem.sv
// N_JOB^2 x COST_W table: one write port, one registered read port, storage not reset.
module jam_cost_mem
  import jam_pkg::*;
(
  input  logic     clk,
  input  logic     we,
  input  tbl_idx_t waddr,
  input  cost_t    wdata,
  input  tbl_idx_t raddr,
  output cost_t    rdata
);

  cost_t mem [TBL_DEPTH];
  cost_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/jam_cost_rom.sv
// Run-time loadable cost table answering Cost(W,J) one cycle after (W,J) is sampled.
// Optional JAM_COST_RDCNT_EN adds a saturating SERVE-cycle counter on RdCount.
module jam_cost_rom
  import jam_pkg::*;
(
  input  logic           CLK,
  input  logic           RST_n,
  jam_cost_rom_if.slave  bus
);

  state_t   state_q, state_d;
  tbl_idx_t idx_q, idx_d;
  logic     ready_q, ready_d;
  logic     tblrdy_q, tblrdy_d;
  logic     cost_vld_q, cost_vld_d;
  logic     xfer;
  cost_t    rd_cost;

  assign xfer = (state_q == LOAD) && ready_q && bus.LoadValid;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cost_vld_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (xfer) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = SERVE;
          end
        end
      end
      SERVE: begin
        cost_vld_d = 1'b1;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    // Reload overrides everything, but the entry offered this cycle is still written.
    if (bus.Reload) begin
      state_d    = LOAD;
      idx_d      = '0;
      cost_vld_d = 1'b0;
    end
    ready_d  = (state_d == LOAD);
    tblrdy_d = (state_d == SERVE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      tblrdy_q   <= 1'b0;
      cost_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      tblrdy_q   <= tblrdy_d;
      cost_vld_q <= cost_vld_d;
    end
  end

  jam_cost_mem u_mem (
    .clk   (CLK),
    .we    (xfer),
    .waddr (idx_q),
    .wdata (bus.LoadData),
    .raddr ({bus.W, bus.J}),
    .rdata (rd_cost)
  );

  // The RAM read register has no reset, so a resettable qualifier forces Cost to 0.
  assign bus.Cost      = cost_vld_q ? rd_cost : '0;
  assign bus.LoadReady = ready_q;
  assign bus.TableRdy  = tblrdy_q;

`ifdef JAM_COST_RDCNT_EN
  logic [15:0] rdcnt_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rdcnt_q <= '0;
    end else if (bus.Reload) begin
      rdcnt_q <= '0;
    end else if ((state_q == SERVE) && (rdcnt_q != 16'hFFFF)) begin
      rdcnt_q <= rdcnt_q + 16'd1;
    end
  end

  assign bus.RdCount = rdcnt_q;
`endif

endmodule

// File: tb/tb_jam_cost_rom.sv
// Scoreboard bench for jam_cost_rom: lookups push expected costs, a negedge monitor pops them.
module tb_jam_cost_rom;
  import jam_pkg::*;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  jam_cost_rom_if bus ();

  jam_cost_rom dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  int    errors = 0;
  int    checks = 0;
  cost_t exp_q[$];
  cost_t tb_mem [TBL_DEPTH];
  int    idx_m = 0;
  logic  lk_active = 1'b0;
  logic  lk_sampled = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic cost_t patval(input int pat, input int i);
    int v;
    case (pat)
      0:       v = (i / 8 + i % 8) % 128;
      1:       v = (i * 3) % 128;
      2:       v = (i * 5 + 1) % 128;
      3:       v = 127 - i;
      4:       v = (i ^ 42) & 127;
      default: v = (i * 7 + 3) % 128;
    endcase
    return cost_t'(v);
  endfunction

  // Monitor: a lookup issued while the table was ready yields Cost one edge later.
  always @(posedge CLK) lk_sampled <= lk_active && bus.TableRdy && RST_n;

  always @(negedge CLK) begin
    cost_t e;
    if (lk_sampled) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lookup_unexpected: got %0d expected none", bus.Cost);
      end else begin
        e = exp_q.pop_front();
        check("lookup_cost", {25'd0, bus.Cost}, {25'd0, e});
      end
    end
  end

  task automatic lookup(input int w, input int j, input cost_t e);
    bus.W = job_idx_t'(w);
    bus.J = job_idx_t'(j);
    exp_q.push_back(e);
    lk_active = 1'b1;
    tick();
    lk_active = 1'b0;
  endtask

  task automatic load_n(input int n, input int pat, input int reload_at);
    for (int i = 0; i < n; i++) begin
      cost_t d;
      d = patval(pat, i);
      bus.LoadValid = 1'b1;
      bus.LoadData  = d;
      bus.Reload    = (i == reload_at);
      check("load_ready", bus.LoadReady, 1);
      if (i == n - 1) check("tblrdy_low_before_last", bus.TableRdy, 0);
      if (i == 0 || i == n / 2) check("cost_zero_in_load", bus.Cost, 0);
      tb_mem[idx_m] = d;
      idx_m = (i == reload_at) ? 0 : (idx_m + 1) % TBL_DEPTH;
      tick();
    end
    bus.LoadValid = 1'b0;
    bus.Reload    = 1'b0;
  endtask

  task automatic pulse_reload();
    bus.Reload = 1'b1;
    tick();
    bus.Reload = 1'b0;
    idx_m = 0;
  endtask

  task automatic verify_table();
    int pts [6] = '{0, 9, 27, 40, 54, 63};
    for (int k = 0; k < 6; k++) begin
      lookup(pts[k] / 8, pts[k] % 8, tb_mem[pts[k]]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.LoadValid = 1'b0;
    bus.LoadData  = '0;
    bus.Reload    = 1'b0;
    bus.W         = '0;
    bus.J         = '0;
    repeat (3) @(negedge CLK);
    check("rst_load_ready", bus.LoadReady, 0);
    check("rst_table_rdy", bus.TableRdy, 0);
    check("rst_cost", bus.Cost, 0);
    RST_n = 1'b1;
    check("pre_edge_load_ready", bus.LoadReady, 0);
    tick();

    // T1: full load of (W+J)%128
    load_n(64, 0, -1);
    check("t1_ready_low", bus.LoadReady, 0);
    check("t1_table_rdy", bus.TableRdy, 1);
    check("t1_cost_zero_first_serve", bus.Cost, 0);

    // T2: back-to-back lookups, hand-computed
    lookup(3, 5, 7'd8);
    lookup(7, 0, 7'd7);
    lookup(0, 7, 7'd7);
    lookup(7, 7, 7'd14);
    lookup(4, 2, 7'd6);
    bus.LoadValid = 1'b1;
    bus.LoadData  = 7'd99;
    tick();
    check("serve_ignores_valid_ready", bus.LoadReady, 0);
    lookup(0, 0, 7'd0);
    bus.LoadValid = 1'b0;

    // T3: Reload during entry 40
    pulse_reload();
    check("t3_tblrdy_after_reload", bus.TableRdy, 0);
    check("t3_ready_after_reload", bus.LoadReady, 1);
    check("t3_cost_after_reload", bus.Cost, 0);
    load_n(41, 1, 40);
    check("t3_tblrdy_mid", bus.TableRdy, 0);
    load_n(64, 2, -1);
    check("t3_table_rdy", bus.TableRdy, 1);
    verify_table();

    // T4: Reload on the 64th transfer
    pulse_reload();
    load_n(64, 3, 63);
    check("t4_tblrdy_stays_low", bus.TableRdy, 0);
    check("t4_ready_stays_high", bus.LoadReady, 1);
    load_n(64, 4, -1);
    check("t4_table_rdy", bus.TableRdy, 1);
    verify_table();

    // T5: async reset mid-serve
    lookup(2, 3, tb_mem[19]);
    #2;
    RST_n = 1'b0;
    #1;
    check("t5_async_cost", bus.Cost, 0);
    check("t5_async_tblrdy", bus.TableRdy, 0);
    check("t5_async_ready", bus.LoadReady, 0);
    @(negedge CLK);
    RST_n = 1'b1;
    idx_m = 0;
    tick();
    load_n(64, 5, -1);
    check("t5_table_rdy", bus.TableRdy, 1);
    verify_table();

`ifdef JAM_COST_RDCNT_EN
    // T6: lookup counter
    pulse_reload();
    check("t6_rdcnt_after_reload", bus.RdCount, 0);
    load_n(64, 0, -1);
    check("t6_rdcnt_after_load", bus.RdCount, 0);
    repeat (100) tick();
    check("t6_rdcnt_100", bus.RdCount, 100);
    pulse_reload();
    check("t6_rdcnt_cleared", bus.RdCount, 0);
`endif

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
